// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA timing generator: default 640x480 timing,
// the rgb_t colour struct and the colour-bar lookup used by the optional test pattern.
package vga_pkg;

  localparam int DEF_CLK_DIV  = 4;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_SRC_W    = 256;
  localparam int DEF_SRC_H    = 240;
  localparam int DEF_SCALE    = 2;
  localparam int DEF_COLOR_W  = 4;

  typedef struct packed {
    logic [DEF_COLOR_W-1:0] r;
    logic [DEF_COLOR_W-1:0] g;
    logic [DEF_COLOR_W-1:0] b;
  } rgb_t;

  // {r,g,b}: each set bit drives that channel to full scale.
  typedef logic [2:0] bar_mask_t;

  // Bars left to right: white, yellow, cyan, green, magenta, red, blue, black.
  function automatic bar_mask_t bar_mask(input logic [2:0] idx);
    case (idx)
      3'd0:    return 3'b111;
      3'd1:    return 3'b110;
      3'd2:    return 3'b011;
      3'd3:    return 3'b010;
      3'd4:    return 3'b101;
      3'd5:    return 3'b100;
      3'd6:    return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One axis (horizontal or vertical) of the VGA raster: a wrapping position counter
// with active-region and sync-region decode. Instantiated once per axis.
module vga_axis_counter #(
  parameter int ACTIVE = 640,
  parameter int FP     = 16,
  parameter int SYNC   = 96,
  parameter int BP     = 48,
  localparam int TOTAL = ACTIVE + FP + SYNC + BP,
  localparam int CW    = $clog2(TOTAL + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic [CW-1:0] cnt,
  output logic [CW-1:0] cnt_next,
  output logic          wrap,
  output logic          active,
  output logic          sync
);

  localparam logic [CW-1:0] LAST     = CW'(TOTAL - 1);
  localparam logic [CW-1:0] ACT_END  = CW'(ACTIVE);
  localparam logic [CW-1:0] SYNC_BEG = CW'(ACTIVE + FP);
  localparam logic [CW-1:0] SYNC_END = CW'(ACTIVE + FP + SYNC);

  // NOTE: every signal driven in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    wrap     = en && (cnt == LAST);
    cnt_next = cnt;
    if (en) cnt_next = (cnt == LAST) ? '0 : cnt + 1'b1;
  end

  // NOTE: state registers use non-blocking assignments and reset asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else     cnt <= cnt_next;
  end

  assign active = (cnt < ACT_END);
  assign sync   = (cnt >= SYNC_BEG) && (cnt < SYNC_END);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator and integer-scaling frame window for a 256x240 NES source image.
// Define VGA_TEST_PATTERN_EN to add the test_en port and the eight-bar colour pattern.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int   CLK_DIV  = DEF_CLK_DIV,
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter int   SRC_W    = DEF_SRC_W,
  parameter int   SRC_H    = DEF_SRC_H,
  parameter int   SCALE    = DEF_SCALE,
  parameter logic SYNC_POL = 1'b0,
  parameter int   COLOR_W  = DEF_COLOR_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3*COLOR_W-1:0] pix_data,
`ifdef VGA_TEST_PATTERN_EN
  input  logic                 test_en,
`endif
  output logic [7:0]           h_c,
  output logic [7:0]           v_c,
  output logic                 src_valid,
  output logic                 frame_start,
  output logic [COLOR_W-1:0]   vgaRed,
  output logic [COLOR_W-1:0]   vgaGreen,
  output logic [COLOR_W-1:0]   vgaBlue,
  output logic                 Hsync,
  output logic                 Vsync
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL + 1);
  localparam int VW      = $clog2(V_TOTAL + 1);
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int SHIFT   = $clog2(SCALE);

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] X_OFF    = HW'((H_ACTIVE - SRC_W * SCALE) / 2);
  localparam logic [VW-1:0] Y_OFF    = VW'((V_ACTIVE - SRC_H * SCALE) / 2);
  localparam logic [HW-1:0] X_SPAN   = HW'(SRC_W * SCALE);
  localparam logic [VW-1:0] Y_SPAN   = VW'(SRC_H * SCALE);

  logic [DW-1:0] div;
  logic          tick;
  logic [HW-1:0] h_cnt, h_next;
  logic [VW-1:0] v_cnt, v_next;
  logic          h_wrap, v_wrap, h_active, v_active, h_sync, v_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       div <= '0;
    else if (tick) div <= '0;
    else           div <= div + 1'b1;
  end

  assign tick = (div == DIV_LAST);

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)
  ) u_h (
    .clk(clk), .rst(rst), .en(tick),
    .cnt(h_cnt), .cnt_next(h_next), .wrap(h_wrap),
    .active(h_active), .sync(h_sync)
  );

  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)
  ) u_v (
    .clk(clk), .rst(rst), .en(h_wrap),
    .cnt(v_cnt), .cnt_next(v_next), .wrap(v_wrap),
    .active(v_active), .sync(v_sync)
  );

  // Window test on the position about to start. Below the offset the subtraction wraps
  // past 2**HW - X_OFF, which always exceeds the span, so one unsigned compare suffices.
  logic [HW-1:0] dx;
  logic [VW-1:0] dy;
  logic          in_win;

  always_comb begin
    dx     = h_next - X_OFF;
    dy     = v_next - Y_OFF;
    in_win = (dx < X_SPAN) && (dy < Y_SPAN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_valid <= 1'b0;
      h_c       <= '0;
      v_c       <= '0;
    end else if (tick) begin
      src_valid <= in_win;
      h_c       <= in_win ? 8'(dx >> SHIFT) : 8'd0;
      v_c       <= in_win ? 8'(dy >> SHIFT) : 8'd0;
    end
  end

  logic [3*COLOR_W-1:0] win_rgb;

`ifdef VGA_TEST_PATTERN_EN
  localparam int BAR_W = SRC_W / 8;
  bar_mask_t bar;

  always_comb begin
    bar     = bar_mask(3'(h_c / BAR_W));
    win_rgb = pix_data;
    if (test_en) win_rgb = {{COLOR_W{bar[2]}}, {COLOR_W{bar[1]}}, {COLOR_W{bar[0]}}};
  end
`else
  assign win_rgb = pix_data;
`endif

  // Colour and sync for slot P are captured on the tick ending P and held through P+1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {vgaRed, vgaGreen, vgaBlue} <= '0;
      Hsync                       <= ~SYNC_POL;
      Vsync                       <= ~SYNC_POL;
    end else if (tick) begin
      {vgaRed, vgaGreen, vgaBlue} <= (h_active && v_active && src_valid) ? win_rgb : '0;
      Hsync                       <= h_sync ? SYNC_POL : ~SYNC_POL;
      Vsync                       <= v_sync ? SYNC_POL : ~SYNC_POL;
    end
  end

  // origin marks the slot at raster (0,0); reset lands there directly.
  logic origin;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      origin      <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      frame_start <= tick && origin;
      if (tick) origin <= v_wrap;
    end
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA timing generator and NES frame scaler. Produces Hsync/Vsync and 4-bit-per-channel colour from a single system clock using an internal pixel-clock divider, and requests source pixels from the PPU frame buffer as NES coordinates (h_c, v_c). The scaled source image is centred in the active area with a black border. Supersedes the fixed 640x480 vga block; every timing value, the scale factor and the sync polarity are parameters.

## Interface
- CLK_DIV, 4: system clocks per pixel slot (≥1; 4 gives 25 MHz from 100 MHz)
- H_ACTIVE, 640 / H_FP, 16 / H_SYNC, 96 / H_BP, 48: horizontal timing in pixels
- V_ACTIVE, 480 / V_FP, 10 / V_SYNC, 2 / V_BP, 33: vertical timing in lines
- SRC_W, 256 / SRC_H, 240: source image size
- SCALE, 2: integer upscale, power of two; SRC_W*SCALE ≤ H_ACTIVE, SRC_H*SCALE ≤ V_ACTIVE
- SYNC_POL, 0: asserted level of Hsync/Vsync (0 = active low)
- COLOR_W, 4: bits per colour channel

- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- pix_data  in  3*COLOR_W  {R,G,B} for the requested coordinate, valid at the end of the requesting slot
- h_c  out  8  source x request
- v_c  out  8  source y request
- src_valid  out  1  h_c/v_c are inside the source window
- frame_start  out  1  one-clock pulse on the tick that begins slot (0,0)
- vgaRed / vgaGreen / vgaBlue  out  COLOR_W each  colour output
- Hsync / Vsync  out  1 each  sync outputs
- test_en  in  1  only when VGA_TEST_PATTERN_EN defined (see Configuration)

## Operation
- Divider counts 0..CLK_DIV-1; tick = clock where it equals CLK_DIV-1. One pixel slot = CLK_DIV clocks.
- h_cnt 0..H_TOTAL-1 (H_TOTAL = sum of H params) advances on tick; wrap to 0 advances v_cnt 0..V_TOTAL-1, which wraps to 0 on the same tick (simultaneous wrap → both zero).
- Active: h_cnt<H_ACTIVE and v_cnt<V_ACTIVE. Hsync asserted for H_ACTIVE+H_FP ≤ h_cnt < H_ACTIVE+H_FP+H_SYNC; Vsync likewise on v_cnt.
- Window offsets X_OFF=(H_ACTIVE-SRC_W*SCALE)/2, Y_OFF=(V_ACTIVE-SRC_H*SCALE)/2 (64, 0 at defaults). src_valid when inside [X_OFF, X_OFF+SRC_W*SCALE) × [Y_OFF, Y_OFF+SRC_H*SCALE).
- h_c=(h_cnt-X_OFF)>>log2(SCALE), v_c likewise; outside window h_c/v_c hold 0.
- Colour: active and src_valid → pix_data; active border → 0; blanking → 0 (mandatory).

## Timing
- Two-stage pipeline in slots: slot P presents h_c/v_c/src_valid for position P; pix_data sampled on the tick ending slot P; colour and sync for P registered on that tick and held through slot P+1. Sync delayed identically, so colour/sync stay aligned.
- Reset values: divider, h_cnt, v_cnt 0; h_c, v_c, src_valid, frame_start 0; colours 0; Hsync/Vsync at deasserted level (~SYNC_POL).
- Reset mid-frame restarts at slot (0,0); first frame_start on the first tick after release.
- CLK_DIV=1: tick every clock, all rules unchanged.

## Configuration
- VGA_TEST_PATTERN_EN defined: test_en port exists; when 1, colour in the source window is eight vertical bars of SRC_W/8 source pixels (white, yellow, cyan, green, magenta, red, blue, black; full-scale channels), pix_data ignored; latency and sync unchanged. Switching takes effect at the next slot.
- Undefined: no test_en port; window colour always pix_data.

## Structure
- vga_pkg: rgb_t struct (COLOR_W per channel), default timing localparams, bar colour constants.
- Sub-module vga_axis_counter: parametrised ACTIVE/FP/SYNC/BP counter with enable, wrap pulse, active and sync decode; instantiated once for h, once for v.

## Test plan
- Defaults, release reset: Hsync falls 657*4=2628 clocks after release, low 96*4=384 clocks, period 3200 clocks.
- Vsync low for 2 lines starting line 490; frame period 420000 slots = 1,680,000 clocks; frame_start exactly once per frame.
- Feed pix_data = {v_c[3:0],h_c[3:0],4'hA}: output at h_cnt 64..65 equals h_c 0, at 575 equals h_c 255; h_cnt 0..63 and 576..639 output 0.
- Constant pix_data 12'hFFF: all colours 0 throughout blanking and border.
- Assert rst at line 100 mid-line: outputs return to reset values asynchronously; after release, timing matches first scenario.
- CLK_DIV=1, SCALE=1, SYNC_POL=1: Hsync high during h_cnt 656..751 (+1 slot latency); h_c window 192..447; with VGA_TEST_PATTERN_EN, test_en=1 gives bar boundaries every 32 source pixels.
